// File: rtl/regfile_pkg.sv
// Shared definitions for the multiport register file: default geometry for
// the MIPS top level and the address-width helper used by every instance.
package regfile_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 32;

    // Smallest n with 2**n >= value; at least 1 so a 2-entry file still has an address bit.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/regfile_word.sv
// One register-file word: async active-high clear, two write ports, port B
// has priority when both enables are high in the same cycle.
module regfile_word
    import regfile_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             we_a_i,
    input  logic             we_b_i,
    input  logic [WIDTH-1:0] data_a_i,
    input  logic [WIDTH-1:0] data_b_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] word_q, word_d;

    // Next value: B beats A on a same-word collision, otherwise hold.
    always_comb begin
        word_d = word_q;
        if (we_b_i)      word_d = data_b_i;
        else if (we_a_i) word_d = data_a_i;
    end

    // Storage with asynchronous clear; clear also masks any write that cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) word_q <= '0;
        else       word_q <= word_d;
    end

    assign q_o = word_q;

endmodule

// File: rtl/regfile_multiport.sv
// Multiport register file for the decode stage: two write ports (load return
// and ALU result), two asynchronous read ports, optional hard-wired zero
// register and optional same-cycle write-to-read forwarding.
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int   WIDTH    = DEF_WIDTH,
    parameter int   DEPTH    = DEF_DEPTH,
    parameter int   ZERO_REG = 1,
    parameter int   BYPASS   = 0,
    localparam int  ADDR_W   = clog2(DEPTH)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [WIDTH-1:0]  WriteDataA,
    input  logic [ADDR_W-1:0] WriteRegisterA,
    input  logic              RegWriteA,
    input  logic [WIDTH-1:0]  WriteDataB,
    input  logic [ADDR_W-1:0] WriteRegisterB,
    input  logic              RegWriteB,
    input  logic [ADDR_W-1:0] ReadRegister1,
    input  logic [ADDR_W-1:0] ReadRegister2,
    output logic [WIDTH-1:0]  ReadData1,
    output logic [WIDTH-1:0]  ReadData2
);

    logic [DEPTH-1:0][WIDTH-1:0] word_q;
    logic                        wr_ok_a, wr_ok_b;
    logic [1:0][ADDR_W-1:0]      raddr;
    logic [1:0][WIDTH-1:0]       rdata;

    // A write address is usable if it names a real word that is not the
    // hard-wired zero register; anything else is silently dropped.
    function automatic logic addr_writable(input logic [ADDR_W-1:0] a);
        logic ok;
        ok = (32'(a) < 32'(DEPTH));
        if (ZERO_REG != 0 && a == '0) ok = 1'b0;
        return ok;
    endfunction

    // Qualified write enables, shared by the word decode and the bypass path.
    always_comb begin
        wr_ok_a = RegWriteA && addr_writable(WriteRegisterA);
        wr_ok_b = RegWriteB && addr_writable(WriteRegisterB);
    end

    // Storage array; word 0 is a constant when the zero register is enabled.
    for (genvar w = 0; w < DEPTH; w++) begin : g_word
        if (ZERO_REG != 0 && w == 0) begin : g_zero
            assign word_q[w] = '0;
        end else begin : g_reg
            logic we_a, we_b;
            assign we_a = wr_ok_a && (WriteRegisterA == ADDR_W'(w));
            assign we_b = wr_ok_b && (WriteRegisterB == ADDR_W'(w));
            regfile_word #(.WIDTH(WIDTH)) u_word (
                .clk_i    (Clk),
                .rst_i    (Reset),
                .we_a_i   (we_a),
                .we_b_i   (we_b),
                .data_a_i (WriteDataA),
                .data_b_i (WriteDataB),
                .q_o      (word_q[w])
            );
        end
    end

    assign raddr[0] = ReadRegister1;
    assign raddr[1] = ReadRegister2;

    // Read select per port: out-of-range addresses fall through to 0; with
    // BYPASS, a qualified write to the same address overrides (B last so it
    // wins, matching the collision rule); Reset forces 0 over everything.
    always_comb begin
        rdata = '0;
        for (int p = 0; p < 2; p++) begin
            for (int w = 0; w < DEPTH; w++) begin
                if (raddr[p] == ADDR_W'(w)) rdata[p] = word_q[w];
            end
            if (BYPASS != 0) begin
                if (wr_ok_a && WriteRegisterA == raddr[p]) rdata[p] = WriteDataA;
                if (wr_ok_b && WriteRegisterB == raddr[p]) rdata[p] = WriteDataB;
            end
            if (Reset) rdata[p] = '0;
        end
    end

    assign ReadData1 = rdata[0];
    assign ReadData2 = rdata[1];

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench: u0 = default (zero reg, no bypass), u1 = no zero reg with
// bypass (shares u0's inputs), u2 = 16x24 with zero reg and bypass.
module tb_regfile_multiport;

    logic        Clk = 1'b0;
    logic        rst;

    logic [31:0] wdA, wdB;
    logic [4:0]  waA, waB, ra1, ra2;
    logic        weA, weB;
    logic [31:0] rd1_0, rd2_0, rd1_1, rd2_1;

    logic [15:0] s_wdA, s_wdB;
    logic [4:0]  s_waA, s_waB, s_ra1, s_ra2;
    logic        s_weA, s_weB;
    logic [15:0] rd1_2, rd2_2;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    regfile_multiport #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1), .BYPASS(0)) u0 (
        .Clk(Clk), .Reset(rst),
        .WriteDataA(wdA), .WriteRegisterA(waA), .RegWriteA(weA),
        .WriteDataB(wdB), .WriteRegisterB(waB), .RegWriteB(weB),
        .ReadRegister1(ra1), .ReadRegister2(ra2),
        .ReadData1(rd1_0), .ReadData2(rd2_0)
    );

    regfile_multiport #(.WIDTH(32), .DEPTH(32), .ZERO_REG(0), .BYPASS(1)) u1 (
        .Clk(Clk), .Reset(rst),
        .WriteDataA(wdA), .WriteRegisterA(waA), .RegWriteA(weA),
        .WriteDataB(wdB), .WriteRegisterB(waB), .RegWriteB(weB),
        .ReadRegister1(ra1), .ReadRegister2(ra2),
        .ReadData1(rd1_1), .ReadData2(rd2_1)
    );

    regfile_multiport #(.WIDTH(16), .DEPTH(24), .ZERO_REG(1), .BYPASS(1)) u2 (
        .Clk(Clk), .Reset(rst),
        .WriteDataA(s_wdA), .WriteRegisterA(s_waA), .RegWriteA(s_weA),
        .WriteDataB(s_wdB), .WriteRegisterB(s_waB), .RegWriteB(s_weB),
        .ReadRegister1(s_ra1), .ReadRegister2(s_ra2),
        .ReadData1(rd1_2), .ReadData2(rd2_2)
    );

    // Advance one edge and land 1 ns after it, then drop the enables.
    task automatic cyc();
        @(posedge Clk);
        #1;
        weA = 1'b0; weB = 1'b0; s_weA = 1'b0; s_weB = 1'b0;
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic test_reset();
        // Reset held from time 0; a bypass-eligible write must not leak through.
        weA = 1'b1; waA = 5'd4; wdA = 32'hCAFE0001; ra1 = 5'd5; ra2 = 5'd4;
        #1;
        total++;
        if (rd1_0 !== 32'h0) begin bad++; $display("FAIL reset_u0_rd1 got=%h want=0", rd1_0); end
        total++;
        if (rd2_1 !== 32'h0) begin bad++; $display("FAIL reset_bypass_suppressed got=%h want=0", rd2_1); end
        weA = 1'b0;
        #11;
        rst = 1'b0;
        cyc();
        total++;
        if (rd2_1 !== 32'h0) begin bad++; $display("FAIL reset_write_dropped got=%h want=0", rd2_1); end
    endtask

    task automatic test_reset_clear();
        weA = 1'b1; waA = 5'd5; wdA = 32'hDEADBEEF; ra1 = 5'd5;
        cyc();
        total++;
        if (rd1_0 !== 32'hDEADBEEF) begin bad++; $display("FAIL clr_prewrite got=%h want=deadbeef", rd1_0); end
        #2 rst = 1'b1;
        #1;
        total++;
        if (rd1_0 !== 32'h0) begin bad++; $display("FAIL clr_async got=%h want=0", rd1_0); end
        #1 rst = 1'b0;
        #1;
        total++;
        if (rd1_0 !== 32'h0) begin bad++; $display("FAIL clr_after_release got=%h want=0", rd1_0); end
    endtask

    task automatic test_dual_write();
        weA = 1'b1; waA = 5'd3; wdA = 32'h11111111;
        weB = 1'b1; waB = 5'd7; wdB = 32'h22222222;
        ra1 = 5'd3; ra2 = 5'd7;
        #1;
        total++;
        if (rd1_0 !== 32'h0) begin bad++; $display("FAIL dual_old_value got=%h want=0", rd1_0); end
        cyc();
        total++;
        if (rd1_0 !== 32'h11111111) begin bad++; $display("FAIL dual_u0_r3 got=%h want=11111111", rd1_0); end
        total++;
        if (rd2_0 !== 32'h22222222) begin bad++; $display("FAIL dual_u0_r7 got=%h want=22222222", rd2_0); end
        total++;
        if (rd2_1 !== 32'h22222222) begin bad++; $display("FAIL dual_u1_r7 got=%h want=22222222", rd2_1); end
    endtask

    task automatic test_collision();
        weA = 1'b1; waA = 5'd9; wdA = 32'hAAAA0000;
        weB = 1'b1; waB = 5'd9; wdB = 32'h0000BBBB;
        ra1 = 5'd9; ra2 = 5'd9;
        #1;
        total++;
        if (rd1_1 !== 32'h0000BBBB) begin bad++; $display("FAIL coll_bypass_b got=%h want=0000bbbb", rd1_1); end
        cyc();
        total++;
        if (rd1_0 !== 32'h0000BBBB) begin bad++; $display("FAIL coll_u0 got=%h want=0000bbbb", rd1_0); end
        total++;
        if (rd2_1 !== 32'h0000BBBB) begin bad++; $display("FAIL coll_u1 got=%h want=0000bbbb", rd2_1); end
    endtask

    task automatic test_zero_reg();
        weA = 1'b1; waA = 5'd0; wdA = 32'hFFFFFFFF;
        weB = 1'b1; waB = 5'd0; wdB = 32'hFFFFFFFF;
        ra1 = 5'd0; ra2 = 5'd0;
        cyc();
        total++;
        if (rd1_0 !== 32'h0) begin bad++; $display("FAIL zero_u0_rd1 got=%h want=0", rd1_0); end
        total++;
        if (rd2_0 !== 32'h0) begin bad++; $display("FAIL zero_u0_rd2 got=%h want=0", rd2_0); end
        total++;
        if (rd1_1 !== 32'hFFFFFFFF) begin bad++; $display("FAIL zero_u1_rd1 got=%h want=ffffffff", rd1_1); end
    endtask

    task automatic test_bypass();
        weA = 1'b1; waA = 5'd4; wdA = 32'h00000001;
        cyc();
        weA = 1'b1; waA = 5'd4; wdA = 32'h5A5A5A5A; ra2 = 5'd4; ra1 = 5'd3;
        #1;
        total++;
        if (rd2_1 !== 32'h5A5A5A5A) begin bad++; $display("FAIL byp_on got=%h want=5a5a5a5a", rd2_1); end
        total++;
        if (rd2_0 !== 32'h00000001) begin bad++; $display("FAIL byp_off_old got=%h want=00000001", rd2_0); end
        total++;
        if (rd1_1 !== 32'h11111111) begin bad++; $display("FAIL byp_other_port got=%h want=11111111", rd1_1); end
        cyc();
        total++;
        if (rd2_0 !== 32'h5A5A5A5A) begin bad++; $display("FAIL byp_off_new got=%h want=5a5a5a5a", rd2_0); end
    endtask

    task automatic test_nonpow2();
        s_weA = 1'b1; s_waA = 5'd6;  s_wdA = 16'h0666;
        s_weB = 1'b1; s_waB = 5'd22; s_wdB = 16'h2222;
        cyc();
        s_weA = 1'b1; s_waA = 5'd30; s_wdA = 16'h1234;
        s_weB = 1'b1; s_waB = 5'd23; s_wdB = 16'h5678;
        s_ra1 = 5'd30; s_ra2 = 5'd0;
        #1;
        total++;
        if (rd1_2 !== 16'h0) begin bad++; $display("FAIL np2_no_oor_bypass got=%h want=0", rd1_2); end
        cyc();
        s_ra1 = 5'd30; s_ra2 = 5'd23;
        #1;
        total++;
        if (rd1_2 !== 16'h0) begin bad++; $display("FAIL np2_oor_read got=%h want=0", rd1_2); end
        total++;
        if (rd2_2 !== 16'h5678) begin bad++; $display("FAIL np2_r23 got=%h want=5678", rd2_2); end
        s_ra1 = 5'd6; s_ra2 = 5'd22;
        #1;
        total++;
        if (rd1_2 !== 16'h0666) begin bad++; $display("FAIL np2_r6 got=%h want=0666", rd1_2); end
        total++;
        if (rd2_2 !== 16'h2222) begin bad++; $display("FAIL np2_r22 got=%h want=2222", rd2_2); end
        s_ra1 = 5'd14; s_ra2 = 5'd0;
        #1;
        total++;
        if (rd1_2 !== 16'h0) begin bad++; $display("FAIL np2_r14_untouched got=%h want=0", rd1_2); end
        total++;
        if (rd2_2 !== 16'h0) begin bad++; $display("FAIL np2_r0 got=%h want=0", rd2_2); end
    endtask

    initial begin
        rst = 1'b1;
        wdA = '0; wdB = '0; waA = '0; waB = '0; weA = 1'b0; weB = 1'b0;
        ra1 = '0; ra2 = '0;
        s_wdA = '0; s_wdB = '0; s_waA = '0; s_waB = '0; s_weA = 1'b0; s_weB = 1'b0;
        s_ra1 = '0; s_ra2 = '0;
        test_reset();
        test_reset_clear();
        test_dual_write();
        test_collision();
        test_zero_reg();
        test_bypass();
        test_nonpow2();
        chk32("final_u1_r3", rd1_1 | 32'h0, rd1_1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
